rns_forward_converter: RTL
==========================

// Module: rns_forward_converter
// PURPOSE
//  Binary-to-RNS forward converter for the moduli set {7, 8, 9} (2^n-1, 2^n, 2^n+1, n=3).
//  Accepts one unsigned binary operand and reduces it bit-serially, MSB first.
//  Produces the three residues consumed by the per-channel residue adders.
//  Sits directly upstream of the mod-8 3-bit adder and its mod-7/mod-9 siblings.
//  Valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//  DATA_W  9  operand width; the RNS dynamic range 0..503 fits in 9 bits
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       converter can accept an operand; high only in IDLE
//  in_data    in   DATA_W  unsigned binary operand
//  out_valid  out  1       res7/res8/res9 hold a completed result
//  out_ready  in   1       consumer accepts the result
//  res7       out  3       in_data mod 7, range 0..6
//  res8       out  3       in_data mod 8, range 0..7
//  res9       out  4       in_data mod 9, range 0..8
//  busy       out  1       high in SHIFT or DONE
// BEHAVIOUR
//  Reset: state=IDLE; all accumulators, res7/res8/res9 and bit counter = 0; out_valid=0.
//   in_ready=1 in the first cycle after reset.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid && in_ready at a clock edge: capture in_data into a shift register,
//     clear acc7/acc8/acc9, load cnt=DATA_W-1, go to SHIFT.
//  SHIFT: one bit per cycle, MSB first, with b = current bit.
//   - acc7 = (2*acc7 + b) mod 7
//   - acc8 = (2*acc8 + b) mod 8
//   - acc9 = (2*acc9 + b) mod 9
//   - Reduction is one conditional subtract: 2*acc+b < 2m always holds.
//     acc8 may use the low 3 bits directly.
//   - Decrement cnt each cycle. On the edge that processes bit 0, load res7/res8/res9
//     from the next accumulator values and go to DONE.
//  DONE:
//   - out_valid=1; res* held stable.
//   - On out_valid && out_ready: go to IDLE.
//   - No operand is accepted in the same cycle as the DONE->IDLE transition.
//  Latency: out_valid rises exactly DATA_W cycles after the accepting edge.
//   Minimum initiation interval is DATA_W+2 cycles.
//  Backpressure: DONE holds indefinitely while out_ready=0; residues do not change.
//  Residue outputs keep the last result outside DONE; consumers qualify with out_valid.
//  in_data values beyond the range 0..503 are reduced exactly as integers.
//   No saturation and no error flag.
//  Reset mid-operation: the in-flight conversion is abandoned.
//   Next cycle state is IDLE with outputs at their reset values.
//  in_valid and in_ready are ignored outside IDLE; in_data need not be held after acceptance.
// TESTING
//  1. Reset, then in_data=0 -> after 9 cycles out_valid=1, res7=0, res8=0, res9=0.
//  2. in_data=503 -> res7=6, res8=7, res9=8; out_valid exactly 9 cycles after accept.
//  3. in_data=100 -> res7=2, res8=4, res9=1; in_data=511 -> res7=0, res8=7, res9=7.
//  4. Hold out_ready=0 for 20 cycles after in_data=100.
//     -> out_valid stays 1, residues constant, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. Pulse rst in the 4th SHIFT cycle of in_data=503.
//     -> next cycle IDLE, out_valid=0, res*=0.
//     A fresh in_data=100 then converts correctly.
//  6. Back-to-back random operands 0..511 with random out_ready stalls.
//     -> every result matches the integer % 7/8/9 model; no operand lost or duplicated.

Source files
------------

// File: rtl/rns_forward_converter.sv
// Bit-serial binary-to-RNS forward converter for the moduli set {7, 8, 9}.
// The operand is consumed MSB first, one bit per cycle, with a Horner-style
// doubling accumulator per channel. One conversion is in flight at a time.
module rns_forward_converter #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        res7,
    output logic [2:0]        res8,
    output logic [3:0]        res9,
    output logic              busy
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        acc7_q, acc7_d;
    logic [2:0]        acc8_q, acc8_d;
    logic [3:0]        acc9_q, acc9_d;
    logic [2:0]        res7_q, res7_d;
    logic [2:0]        res8_q, res8_d;
    logic [3:0]        res9_q, res9_d;

    logic       bit_in;
    logic [3:0] dbl7;
    logic [4:0] dbl9;
    logic [2:0] nxt7;
    logic [2:0] nxt8;
    logic [3:0] nxt9;

    // One accumulator step: double, add the current bit, then a single
    // conditional subtract since 2*acc+b never reaches twice the modulus.
    always_comb begin
        bit_in = sr_q[DATA_W-1];
        dbl7   = {acc7_q, bit_in};
        dbl9   = {acc9_q, bit_in};
        nxt7   = (dbl7 >= 4'd7) ? 3'(dbl7 - 4'd7) : dbl7[2:0];
        nxt8   = {acc8_q[1:0], bit_in};
        nxt9   = (dbl9 >= 5'd9) ? 4'(dbl9 - 5'd9) : dbl9[3:0];
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        acc7_d  = acc7_q;
        acc8_d  = acc8_q;
        acc9_d  = acc9_q;
        res7_d  = res7_q;
        res8_d  = res8_q;
        res9_d  = res9_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    acc7_d  = '0;
                    acc8_d  = '0;
                    acc9_d  = '0;
                    cnt_d   = CntW'(DATA_W - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d   = sr_q << 1;
                acc7_d = nxt7;
                acc8_d = nxt8;
                acc9_d = nxt9;
                cnt_d  = cnt_q - CntW'(1);
                // Bit 0 is being absorbed: publish the finished residues.
                if (cnt_q == '0) begin
                    res7_d  = nxt7;
                    res8_d  = nxt8;
                    res9_d  = nxt9;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            acc7_q  <= '0;
            acc8_q  <= '0;
            acc9_q  <= '0;
            res7_q  <= '0;
            res8_q  <= '0;
            res9_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            acc7_q  <= acc7_d;
            acc8_q  <= acc8_d;
            acc9_q  <= acc9_d;
            res7_q  <= res7_d;
            res8_q  <= res8_d;
            res9_q  <= res9_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StShift) || (state_q == StDone);
        res7      = res7_q;
        res8      = res8_q;
        res9      = res9_q;
    end

endmodule
